sipo_deser_hs: RTL
==================

Name: sipo_deser_hs

Overview:
- Parametrised serial-in/parallel-out deserializer. Successor to the fixed 1-to-8 SIPO used in the AES datapath.
- Accepts IN_W-bit beats on a valid/ready handshake and assembles them into OUT_W-bit words.
- Delivers each word through a registered valid/ready output stage, so back-to-back words stream with no bubble.
- Sits between the bit/byte-serial key/data loader and the AES state/key registers.

Parameters:
- IN_W, 1, input beat width in bits; OUT_W % IN_W == 0 required.
- OUT_W, 8, output word width in bits; BEATS = OUT_W/IN_W, with 2 <= BEATS <= 256.
- MSB_FIRST, 0, 0: beat i lands at bits [i*IN_W +: IN_W]; 1: beat i lands at bits [OUT_W-(i+1)*IN_W +: IN_W].

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous abort; drops the partial word and the pending output
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_data  in  IN_W  input beat
- out_valid  out  1  out_data holds a complete word
- out_ready  in  1  downstream accepts the word
- out_data  out  OUT_W  assembled word, registered
- busy  out  1  cnt != 0 or out_valid

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values: cnt=0, acc=0, out_data=0, out_valid=0. Therefore in_ready=1 and busy=0.
- Internal counter cnt has width clog2(BEATS+1).
  - State FILL: cnt in 0..BEATS-1.
  - State FULL: cnt == BEATS.
- in_ready = (cnt != BEATS). This is registered-state only and has no combinational path from out_ready.
- Definitions: accept = in_valid && in_ready; out_free = !out_valid || out_ready.
- FILL, accept of a beat with cnt < BEATS-1:
  - Write in_data into acc at the slot for index cnt (per MSB_FIRST).
  - cnt <= cnt+1.
- FILL, accept of the last beat (cnt == BEATS-1):
  - If out_free: out_data <= acc with the final beat merged, out_valid <= 1, cnt <= 0. Latency is 0 cycles: out_valid is high after the same edge that accepted the last beat.
  - Else: store the beat in acc, cnt <= BEATS, enter FULL.
- FULL: hold acc. When out_free, load out_data <= acc, out_valid <= 1, cnt <= 0. in_ready returns high the next cycle.
- Output stage:
  - out_valid && out_ready with no new word loading → out_valid <= 0.
  - out_data is held until the handshake. It is not cleared after consumption.
- Simultaneous consume and load: out_ready=1 while a new word loads → out_valid stays 1 and out_data is replaced.
- Throughput: sustained 1 word per BEATS cycles when in_valid and out_ready are constantly high.
- clear: highest priority after reset. It forces cnt <= 0 and out_valid <= 0, and ignores in_valid that cycle. acc is not cleared, because stale slots are overwritten before reuse.
- Reset mid-word: all state is dropped immediately (asynchronous). There is no partial output.
- in_data while in_valid=0 is ignored.

Optional Feature:
- Macro SIPO_FLUSH_EN.
- Defined:
  - Adds input flush (1 bit) and output out_beats (clog2(BEATS+1) bits).
  - flush in FILL with cnt > 0 and out_free: emit the partial word with unfilled slots zero, out_beats = cnt, and cnt <= 0. flush with cnt == 0 is a no-op.
  - flush with a simultaneous accept: the beat is included before emission.
  - Full words report out_beats = BEATS. Reset value of out_beats is 0.
  - clear overrides flush.
- Undefined: no flush or out_beats ports; only whole words are emitted.

Decomposition:
- Package sipo_pkg:
  - function sipo_beats(OUT_W, IN_W);
  - function for cnt width (clog2);
  - localparam slot-offset function shared by both MSB_FIRST modes.
- One sub-module, sipo_out_stage: OUT_W-wide valid/ready holding register with a load input and an out_free output. It is reused by other serial loaders.

Test Plan:
- IN_W=1, OUT_W=8, MSB_FIRST=0, out_ready=1; bits 1,0,1,1,0,0,1,0 → out_data=8'h4D, out_valid for 1 cycle, next word starts with no bubble.
- IN_W=8, OUT_W=32, MSB_FIRST=1; beats 8'hDE,AD,BE,EF, out_ready=1 → out_data=32'hDEADBEEF after the 4th accept edge; 10 back-to-back words at 1 per 4 cycles.
- OUT_W=8 word pending, out_ready=0; feed 8 more bits → in_ready drops after the 8th beat (FULL); raise out_ready for 1 cycle → second word loads, out_valid stays 1, in_ready=1 next cycle.
- 3 beats accepted then clear=1 with in_valid=1 → cnt=0, out_valid=0; the next 8 beats form a clean word.
- Assert reset mid-word (cnt=5) and while out_valid=1 → all outputs at reset values immediately; no word is emitted.
- With SIPO_FLUSH_EN, IN_W=8, OUT_W=32: 2 beats 8'hAA,8'hBB then flush → out_data=32'h0000BBAA, out_beats=2.

Source files
------------

// File: rtl/sipo_deser_hs_pkg.sv
// Shared types and sizing helpers for the parametrised SIPO deserializer
// and the serial loaders that reuse its output stage.
package sipo_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } sipo_state_e;

  function automatic int sipo_beats(input int out_w, input int in_w);
    return out_w / in_w;
  endfunction

  function automatic int sipo_cnt_w(input int beats);
    return $clog2(beats + 1);
  endfunction

  // Bit offset of beat idx inside the word, for either beat ordering.
  function automatic int sipo_slot_lsb(input int idx, input int beats,
                                       input int in_w, input int msb_first);
    if (msb_first != 0) begin
      return (beats - 1 - idx) * in_w;
    end else begin
      return idx * in_w;
    end
  endfunction

endpackage

// File: rtl/sipo_deser_hs_if.sv
// Beat-in / word-out handshake bundle of sipo_deser_hs.
// SIPO_FLUSH_EN adds the flush request and the out_beats word length.
interface sipo_deser_hs_if
  import sipo_pkg::*;
#(
  parameter int IN_W  = 1,
  parameter int OUT_W = 8
);
  localparam int CNT_W = sipo_cnt_w(sipo_beats(OUT_W, IN_W));

  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             busy;
`ifdef SIPO_FLUSH_EN
  logic             flush;
  logic [CNT_W-1:0] out_beats;

  modport slave (input clear, in_valid, in_data, out_ready, flush,
                 output in_ready, out_valid, out_data, busy, out_beats);
  modport master (output clear, in_valid, in_data, out_ready, flush,
                  input in_ready, out_valid, out_data, busy, out_beats);
`else
  modport slave (input clear, in_valid, in_data, out_ready,
                 output in_ready, out_valid, out_data, busy);
  modport master (output clear, in_valid, in_data, out_ready,
                  input in_ready, out_valid, out_data, busy);
`endif

endinterface

// File: rtl/sipo_deser_hs_out_stage.sv
// Generic registered valid/ready word holder; the producer may load only
// while out_free is high, so a consume and a reload can share one edge.
module sipo_out_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_free
);

  logic         valid_r;
  logic [W-1:0] data_r;

  assign out_free  = !valid_r || out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Holding register: data is kept after consumption, only valid drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= {W{1'b0}};
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/sipo_deser_hs.sv
// Parametrised serial-in/parallel-out deserializer with a registered output
// stage. Optional partial-word flush is built when SIPO_FLUSH_EN is defined.
module sipo_deser_hs
  import sipo_pkg::*;
#(
  parameter int IN_W      = 1,
  parameter int OUT_W     = 8,
  parameter int MSB_FIRST = 0
) (
  input logic            clk,
  input logic            reset,
  sipo_deser_hs_if.slave bus
);

  localparam int BEATS = sipo_beats(OUT_W, IN_W);
  localparam int CNT_W = sipo_cnt_w(BEATS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [OUT_W-1:0] acc_r, acc_nxt_s, acc_merged_s, load_data_s;
  logic             accept_s, out_free_s, load_s;
  sipo_state_e      state_s;

  assign state_s      = (cnt_r == CNT_FULL) ? ST_FULL : ST_FILL;
  assign bus.in_ready = (cnt_r != CNT_FULL);
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign bus.busy     = (cnt_r != CNT_ZERO) || bus.out_valid;

  // Accumulator view with the beat being accepted this cycle dropped in place.
  always_comb begin
    acc_merged_s = acc_r;
    for (int i = 0; i < BEATS; i++) begin
      acc_merged_s[sipo_slot_lsb(i, BEATS, IN_W, MSB_FIRST) +: IN_W] =
        (accept_s && (cnt_r == CNT_W'(i))) ? bus.in_data
                                            : acc_r[sipo_slot_lsb(i, BEATS, IN_W, MSB_FIRST) +: IN_W];
    end
  end

`ifdef SIPO_FLUSH_EN
  logic [CNT_W-1:0] fill_s, beats_nxt_s, out_beats_r;
  logic [OUT_W-1:0] partial_s;
  logic             flush_go_s;

  assign fill_s        = cnt_r + {{(CNT_W-1){1'b0}}, accept_s};
  assign flush_go_s    = bus.flush && out_free_s && (fill_s != CNT_ZERO);
  assign bus.out_beats = out_beats_r;

  // Partial word: slots beyond the fill level read as zero, not stale data.
  always_comb begin
    partial_s = {OUT_W{1'b0}};
    for (int i = 0; i < BEATS; i++) begin
      partial_s[sipo_slot_lsb(i, BEATS, IN_W, MSB_FIRST) +: IN_W] =
        (CNT_W'(i) < fill_s) ? acc_merged_s[sipo_slot_lsb(i, BEATS, IN_W, MSB_FIRST) +: IN_W]
                             : {IN_W{1'b0}};
    end
  end
`endif

  // Next-state and load decision for FILL/FULL.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    acc_nxt_s   = acc_r;
    load_s      = 1'b0;
    load_data_s = acc_merged_s;
`ifdef SIPO_FLUSH_EN
    beats_nxt_s = CNT_FULL;
`endif
    if (bus.clear) begin
      cnt_nxt_s = CNT_ZERO;
    end else begin
      case (state_s)
        ST_FULL: begin
          if (out_free_s) begin
            load_s      = 1'b1;
            load_data_s = acc_r;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        ST_FILL: begin
          if (accept_s && (cnt_r == CNT_LAST)) begin
            if (out_free_s) begin
              load_s    = 1'b1;
              cnt_nxt_s = CNT_ZERO;
            end else begin
              acc_nxt_s = acc_merged_s;
              cnt_nxt_s = CNT_FULL;
            end
          end
`ifdef SIPO_FLUSH_EN
          else if (flush_go_s) begin
            load_s      = 1'b1;
            load_data_s = partial_s;
            beats_nxt_s = fill_s;
            acc_nxt_s   = acc_merged_s;
            cnt_nxt_s   = CNT_ZERO;
          end
`endif
          else if (accept_s) begin
            acc_nxt_s = acc_merged_s;
            cnt_nxt_s = cnt_r + CNT_ONE;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        default: begin
          cnt_nxt_s = CNT_ZERO;
        end
      endcase
    end
  end

  // Beat counter and accumulator registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= CNT_ZERO;
      acc_r <= {OUT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
      acc_r <= acc_nxt_s;
    end
  end

`ifdef SIPO_FLUSH_EN
  // Word length travels with the word it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_beats_r <= CNT_ZERO;
    end else if (load_s) begin
      out_beats_r <= beats_nxt_s;
    end else begin
      out_beats_r <= out_beats_r;
    end
  end
`endif

  sipo_out_stage #(.W(OUT_W)) u_out_stage (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.clear),
    .load      (load_s),
    .load_data (load_data_s),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .out_free  (out_free_s)
  );

endmodule
